ring_rr_arbiter: RTL
====================

Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters.
- Priority rotates via a one-hot ring pointer, so fairness is by construction.
- Grants are registered and held until the owner releases or the hold limit expires.
- Sits in front of any shared datapath in the Control/Counter family that needs time-multiplexed ownership.

Parameters:
- N, 8, number of requesters (1..32).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 means unlimited.
- IDXW, $clog2(N) (minimum 1), width of gnt_idx.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- enable  input  1  high allows new grants; low blocks new grants but does not revoke the current grant.
- req  input  N  level request per requester; bit i held high while requester i wants ownership.
- gnt  output  N  registered one-hot grant (all zero when idle).
- gnt_valid  output  1  OR of gnt, registered.
- gnt_idx  output  IDXW  binary index of the owner; 0 when idle.
- preempt  output  1  one-cycle pulse when a grant is revoked by hold timeout.
- ptr  output  N  current one-hot priority pointer, for debug and coverage.

Behaviour:
- Reset (async, immediate):
  - gnt=0, gnt_valid=0, gnt_idx=0, preempt=0.
  - ptr=1 (bit0), state=IDLE, hold_cnt=0.
  - Applies mid-grant too: the grant drops immediately with no preempt pulse.
- States:
  - IDLE: no owner.
  - BUSY: gnt holds the owner.
  - GAP: one mandatory idle cycle after every release.
- IDLE:
  - If enable=1 and req!=0, the winner is the first set req bit at or above ptr's position, searching upward with wrap from N-1 to 0.
  - Next edge: gnt=winner one-hot, gnt_idx=winner index, hold_cnt=1, state=BUSY.
  - Latency from req sampled high to gnt high is 1 cycle.
  - If enable=0 or req=0, stay in IDLE.
- BUSY, normal release:
  - Sampled each edge.
  - If req[owner]=0: gnt=0, ptr=rotate-left of owner one-hot (owner+1, wrap N-1 to 0), state=GAP.
- BUSY, timeout:
  - Applies when MAX_HOLD!=0, req[owner]=1 and hold_cnt==MAX_HOLD.
  - Same as release, plus preempt=1 for exactly that one cycle.
  - The owner gets gnt high for exactly MAX_HOLD cycles.
- BUSY, otherwise: hold gnt and increment hold_cnt, saturating at MAX_HOLD.
- GAP: gnt=0 for one cycle, then IDLE arbitration happens on the next edge. Minimum spacing between two grants is therefore 1 idle cycle.
- Ignored and blocked events:
  - Non-owner req changes during BUSY or GAP are ignored.
  - The pointer only moves on release or timeout, never while idle.
  - enable dropping during BUSY has no effect on the current grant. Only the next IDLE arbitration is blocked.
- Preempted owner with req still high: it is eligible again but has the lowest priority, because ptr has moved past it.
- N=1: ptr stays 1. The single requester is re-granted after each GAP.
- Every output is a flop, with no combinational path from req to gnt.

Decomposition:
- Package ring_arb_pkg holds:
  - the state enum {IDLE, BUSY, GAP};
  - function rotl1(onehot, N);
  - function onehot2idx.
- Sub-module rr_pick: purely combinational. Inputs req and ptr; outputs winner one-hot and winner_found. Uses the double-width mask-and-priority technique.
- The top holds the FSM, hold counter, ptr register and output flops.

Test Plan (N=8, MAX_HOLD=4 unless noted):
- Reset then req=8'h01 held 2 cycles, then 0:
  - gnt=8'h01 one cycle after req, held 2 cycles.
  - gnt=0 in GAP; ptr=8'h02.
- req=8'hFF held constant: grants rotate 01,02,04,...,80,01.
  - Each owner lasts 4 cycles with preempt pulses, separated by 1 idle cycle.
  - gnt_idx steps 0..7..0.
- ptr=8'h40 and req=8'h81:
  - winner is bit7 (gnt=8'h80, gnt_idx=7).
  - After release, ptr=8'h01, then bit0 is granted.
- MAX_HOLD=0, req=8'h08 held 100 cycles: gnt=8'h08 for all 100 cycles, preempt never asserts.
- enable=0 with req=8'h10: gnt stays 0. Raise enable: gnt=8'h10 one cycle later.
  - Drop enable mid-grant: the grant persists until req[4] drops.
- Assert reset asynchronously mid-grant, between clock edges: gnt, gnt_valid and preempt go 0 immediately, ptr=8'h01.
  - After reset deasserts with req=8'hFF, the first grant is 8'h01.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, GAP)
//   rotl1       : rotate a one-hot vector of width n left by one, wrapping bit n-1 to bit 0
//   onehot2idx  : binary index of the set bit of a one-hot vector (0 when empty)
package ring_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Vectors are carried at the widest supported size (32) and callers truncate.
  function automatic logic [31:0] rotl1(input logic [31:0] onehot, input int n);
    logic [31:0] mask;
    logic [31:0] res;
    mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    res  = (onehot << 1) & mask;
    // The top bit of the ring wraps to position 0.
    res  = res | {31'd0, onehot[5'(n - 1)]};
    return res;
  endfunction

  function automatic logic [4:0] onehot2idx(input logic [31:0] onehot);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) begin
        idx = idx | 5'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_rr_pick.sv
// Combinational round-robin pick.
//   req          : request vector
//   ptr          : one-hot priority pointer (search starts here, wraps upward)
//   winner       : one-hot winner (zero when no request)
//   winner_found : any request present
// The request vector is duplicated so that the wrap-around search becomes a
// plain "lowest set bit at or above ptr" which subtract-and-mask finds directly.
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] winner,
  output logic         winner_found
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_gnt;

  assign dbl_req = {req, req};
  // Subtracting ptr clears the first set bit at or above ptr; masking keeps only it.
  assign dbl_gnt = dbl_req & ~(dbl_req - {{N{1'b0}}, ptr});
  assign winner = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
  assign winner_found = |req;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high reset
//   enable    : allows new grants (never revokes an existing one)
//   req       : level request per requester
//   gnt       : registered one-hot grant
//   gnt_valid : registered OR of gnt
//   gnt_idx   : registered binary index of the owner (0 when idle)
//   preempt   : one-cycle pulse when a grant is revoked by hold timeout
//   ptr       : registered one-hot priority pointer
// A grant lasts until the owner drops its request or MAX_HOLD cycles elapse
// (MAX_HOLD=0 disables the limit). Every release is followed by one idle
// cycle in GAP, during which the next arbitration is evaluated.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int IDXW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic            preempt,
  output logic [N-1:0]    ptr
);

  localparam int HCW          = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit HOLD_LIMITED = (MAX_HOLD != 0);

  arb_state_t     state;
  logic [HCW-1:0] hold_cnt;

  logic [N-1:0]    winner;
  logic            winner_found;
  logic            owner_req;
  logic            hold_expired;
  logic [N-1:0]    next_ptr;
  logic [IDXW-1:0] winner_idx;

  rr_pick #(.N(N)) u_pick (
    .req          (req),
    .ptr          (ptr),
    .winner       (winner),
    .winner_found (winner_found)
  );

  // Decode of the current owner's status and the values loaded on the next edge.
  always_comb begin
    owner_req    = |(req & gnt);
    hold_expired = 1'b0;
    if (HOLD_LIMITED) begin
      hold_expired = (hold_cnt == HCW'(MAX_HOLD));
    end else begin
      hold_expired = 1'b0;
    end
    next_ptr   = N'(rotl1(32'(gnt), N));
    winner_idx = IDXW'(onehot2idx(32'(winner)));
  end

  // Arbiter FSM with hold counter, pointer and all output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= HCW'(0);
      gnt       <= {N{1'b0}};
      gnt_valid <= 1'b0;
      gnt_idx   <= {IDXW{1'b0}};
      preempt   <= 1'b0;
      ptr       <= {{(N-1){1'b0}}, 1'b1};
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (enable && winner_found) begin
            gnt       <= winner;
            gnt_valid <= 1'b1;
            gnt_idx   <= winner_idx;
            hold_cnt  <= HCW'(1);
            state     <= BUSY;
          end else begin
            gnt       <= {N{1'b0}};
            gnt_valid <= 1'b0;
            gnt_idx   <= {IDXW{1'b0}};
            state     <= IDLE;
          end
        end
        BUSY: begin
          if (!owner_req || hold_expired) begin
            gnt       <= {N{1'b0}};
            gnt_valid <= 1'b0;
            gnt_idx   <= {IDXW{1'b0}};
            ptr       <= next_ptr;
            hold_cnt  <= HCW'(0);
            preempt   <= owner_req;  // only a timeout revokes a still-requesting owner
            state     <= GAP;
          end else if (HOLD_LIMITED && (hold_cnt < HCW'(MAX_HOLD))) begin
            hold_cnt <= hold_cnt + HCW'(1);
          end else begin
            hold_cnt <= hold_cnt;
          end
        end
        default: begin
          gnt       <= {N{1'b0}};
          gnt_valid <= 1'b0;
          gnt_idx   <= {IDXW{1'b0}};
          hold_cnt  <= HCW'(0);
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
